// File: rtl/definitions_pkg.sv
// Shared types for the signed seven-segment display path: sample type,
// active-low segment codes, controller states and small datapath helpers.
package definitions_pkg;

    localparam int DATA_W     = 8;
    localparam int DIGIT_W    = 4;
    localparam int BCD_W      = 3 * DIGIT_W;
    localparam int NUM_DIGITS = 4;

    typedef logic signed [DATA_W-1:0] int8_t;

    // Active-low, bit order {g,f,e,d,c,b,a}
    typedef enum logic [6:0] {
        OFF   = 7'h7F,
        MINUS = 7'h3F,
        D0    = 7'h40,
        D1    = 7'h79,
        D2    = 7'h24,
        D3    = 7'h30,
        D4    = 7'h19,
        D5    = 7'h12,
        D6    = 7'h02,
        D7    = 7'h78,
        D8    = 7'h00,
        D9    = 7'h10
    } segment_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LATCH   = 2'd2
    } disp_state_e;

    function automatic segment_e bcd_to_seg(input logic [DIGIT_W-1:0] digit);
        segment_e seg;
        case (digit)
            4'd0:    seg = D0;
            4'd1:    seg = D1;
            4'd2:    seg = D2;
            4'd3:    seg = D3;
            4'd4:    seg = D4;
            4'd5:    seg = D5;
            4'd6:    seg = D6;
            4'd7:    seg = D7;
            4'd8:    seg = D8;
            4'd9:    seg = D9;
            default: seg = OFF;
        endcase
        return seg;
    endfunction

    // Double-dabble correction applied to one BCD nibble before each shift
    function automatic logic [DIGIT_W-1:0] dd_adjust(input logic [DIGIT_W-1:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low segment pattern, with a blanking input
// used for leading-zero suppression.
module seven_seg_decoder
    import definitions_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output segment_e   o_seg
);

    always_comb begin
        o_seg = OFF;
        if (!i_blank) begin
            o_seg = bcd_to_seg(i_bcd);
        end
    end

endmodule

// File: rtl/signed_display_ctrl.sv
// Accepts signed 8-bit samples, converts |x| to BCD by sequential double-dabble
// and scans sign + three digits onto a 4-digit common-anode display.
module signed_display_ctrl
    import definitions_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_done,
    output logic [3:0] o_an,
    output logic [6:0] o_seg
);

    localparam int                DIV_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam int                SLOT_W    = $clog2(NUM_DIGITS);
    localparam int                ITER_W    = $clog2(DATA_W);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DATA_W - 1);

    disp_state_e             r_state;
    disp_state_e             w_state_next;
    logic                    r_latch_phase;
    logic                    r_sign;
    logic [DATA_W-1:0]       r_mag;
    logic [BCD_W-1:0]        r_bcd;
    logic [BCD_W-1:0]        w_bcd_adj;
    logic [ITER_W-1:0]       r_iter;
    logic                    r_done;

    logic                    r_disp_sign;
    logic                    w_disp_sign_next;
    logic [BCD_W-1:0]        r_disp_bcd;
    logic [BCD_W-1:0]        w_disp_bcd_next;

    logic [DIV_W-1:0]        r_div;
    logic [SLOT_W-1:0]       r_slot;
    logic [SLOT_W-1:0]       w_slot_next;
    logic                    w_div_wrap;
    logic [NUM_DIGITS-1:0]   r_an;
    segment_e                r_seg;
    segment_e                w_seg_next;
    segment_e                w_dec_seg;
    logic [DIGIT_W-1:0]      w_dec_bcd;
    logic                    w_dec_blank;

    logic                    w_ready;
    logic                    w_handshake;
    logic                    w_step;
    logic                    w_load;
    logic                    w_done_next;

    int8_t                   w_sample;
    logic                    w_in_sign;
    logic [DATA_W-1:0]       w_in_mag;

    // Negating -128 wraps back to 8'h80, which is exactly 128 unsigned
    assign w_sample  = int8_t'(i_data);
    assign w_in_sign = w_sample[DATA_W-1];
    assign w_in_mag  = w_in_sign ? DATA_W'(-w_sample) : DATA_W'(w_sample);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_handshake)          w_state_next = CONVERT;
            CONVERT: if (r_iter == ITER_LAST)  w_state_next = LATCH;
            LATCH:   if (r_latch_phase)        w_state_next = IDLE;
            default:                           w_state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // LATCH spans two cycles: load the display, then announce it with o_done.
    always_comb begin
        w_ready     = 1'b0;
        w_step      = 1'b0;
        w_load      = 1'b0;
        w_done_next = 1'b0;
        case (r_state)
            IDLE:    w_ready = 1'b1;
            CONVERT: w_step  = 1'b1;
            LATCH: begin
                w_load      = !r_latch_phase;
                w_done_next = r_latch_phase;
            end
            default: ;
        endcase
    end

    assign w_handshake = w_ready & i_valid;
    assign o_ready     = w_ready;
    assign o_done      = r_done;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dd_adj
            assign w_bcd_adj[gi*DIGIT_W +: DIGIT_W] = dd_adjust(r_bcd[gi*DIGIT_W +: DIGIT_W]);
        end
    endgenerate

    assign w_disp_sign_next = w_load ? r_sign : r_disp_sign;
    assign w_disp_bcd_next  = w_load ? r_bcd  : r_disp_bcd;

    // ---------------- Conversion datapath and display registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign        <= 1'b0;
            r_mag         <= '0;
            r_bcd         <= '0;
            r_iter        <= '0;
            r_latch_phase <= 1'b0;
            r_done        <= 1'b0;
            r_disp_sign   <= 1'b0;
            r_disp_bcd    <= '0;
        end else begin
            r_done        <= w_done_next;
            r_latch_phase <= w_load;
            r_disp_sign   <= w_disp_sign_next;
            r_disp_bcd    <= w_disp_bcd_next;
            if (w_handshake) begin
                r_sign <= w_in_sign;
                r_mag  <= w_in_mag;
                r_bcd  <= '0;
                r_iter <= '0;
            end else if (w_step) begin
                {r_bcd, r_mag} <= {w_bcd_adj, r_mag} << 1;
                r_iter         <= r_iter + 1'b1;
            end
        end
    end

    // ---------------- Scanner ----------------
    assign w_div_wrap  = (r_div == DIV_LAST);
    assign w_slot_next = w_div_wrap ? r_slot + 1'b1 : r_slot;

    // Outputs are registered from next-cycle values so a LATCH edge that
    // coincides with a slot advance shows the new data on the new slot.
    always_comb begin
        w_dec_bcd   = w_disp_bcd_next[DIGIT_W-1:0];
        w_dec_blank = 1'b0;
        case (w_slot_next)
            2'd1: begin
                w_dec_bcd   = w_disp_bcd_next[2*DIGIT_W-1:DIGIT_W];
                w_dec_blank = (w_disp_bcd_next[BCD_W-1:DIGIT_W] == '0);
            end
            2'd2: begin
                w_dec_bcd   = w_disp_bcd_next[BCD_W-1:2*DIGIT_W];
                w_dec_blank = (w_disp_bcd_next[BCD_W-1:2*DIGIT_W] == '0);
            end
            default: ;
        endcase
    end

    seven_seg_decoder u_dec (
        .i_bcd   (w_dec_bcd),
        .i_blank (w_dec_blank),
        .o_seg   (w_dec_seg)
    );

    always_comb begin
        w_seg_next = w_dec_seg;
        if (w_slot_next == 2'd3) begin
            w_seg_next = w_disp_sign_next ? MINUS : OFF;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_slot <= '0;
            r_an   <= 4'b1110;
            r_seg  <= D0;
        end else begin
            r_div  <= w_div_wrap ? '0 : r_div + 1'b1;
            r_slot <= w_slot_next;
            r_an   <= ~(NUM_DIGITS'(1) << w_slot_next);
            r_seg  <= w_seg_next;
        end
    end

    assign o_an  = r_an;
    assign o_seg = r_seg;

endmodule

// File: tb/tb_signed_display_ctrl.sv
// Directed bench for signed_display_ctrl with a fast scan rate.
module tb_signed_display_ctrl;

    localparam logic [6:0] S_OFF = 7'h7F;
    localparam logic [6:0] S_MIN = 7'h3F;
    localparam logic [6:0] S_D0  = 7'h40;
    localparam logic [6:0] S_D1  = 7'h79;
    localparam logic [6:0] S_D2  = 7'h24;
    localparam logic [6:0] S_D4  = 7'h19;
    localparam logic [6:0] S_D5  = 7'h12;
    localparam logic [6:0] S_D7  = 7'h78;
    localparam logic [6:0] S_D8  = 7'h00;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_done;
    logic [3:0] o_an;
    logic [6:0] o_seg;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    signed_display_ctrl #(.REFRESH_DIV(4)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_done  (o_done),
        .o_an    (o_an),
        .o_seg   (o_seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // Collects {sign, hundreds, tens, units} segment patterns from one scan.
    task automatic read_digits(output logic [27:0] segs);
        logic [3:0] pat;
        logic       found;
        segs = '1;
        for (int s = 0; s < 4; s++) begin
            pat   = ~(4'b0001 << s);
            found = 1'b0;
            for (int c = 0; c < 40 && !found; c++) begin
                @(negedge clk);
                if (o_an === pat) begin
                    segs[s*7 +: 7] = o_seg;
                    found = 1'b1;
                end
            end
            if (!found) begin
                checks++; errors++;
                $display("FAIL scan_timeout slot %0d o_an=%b", s, o_an);
            end
        end
    endtask

    // Sends one sample with a bounded handshake and waits for o_done.
    task automatic do_sample(input logic [7:0] d, output int lat, output logic busy_rdy,
                             output logic done_after, output logic [27:0] segs);
        int hs;
        int c;
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        c = 0;
        while (!o_ready && c < 40) begin @(negedge clk); c++; end
        if (!o_ready) begin
            checks++; errors++;
            $display("FAIL handshake_timeout data=%h", d);
        end
        hs = cyc + 1;
        @(posedge clk); #1 i_valid = 1'b0;
        @(negedge clk);
        busy_rdy = o_ready;
        c = 0;
        while (!o_done && c < 40) begin @(negedge clk); c++; end
        if (!o_done) begin
            checks++; errors++;
            $display("FAIL done_timeout data=%h", d);
        end
        lat = cyc - hs;
        @(negedge clk);
        done_after = o_done;
        read_digits(segs);
        $display("sample %h: done latency %0d, digits %h", d, lat, segs);
    endtask

    task automatic test_reset;
        int          lat;
        logic        busy_rdy;
        logic        done_after;
        logic [27:0] segs;
        @(negedge clk); i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        checks++; if (o_an !== 4'b1110) begin errors++; $display("FAIL reset_an got %b exp 1110", o_an); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", o_ready); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", o_done); end
        checks++; if (o_seg !== S_D0) begin errors++; $display("FAIL reset_seg got %h exp %h", o_seg, S_D0); end
        do_sample(8'd0, lat, busy_rdy, done_after, segs);
        checks++; if (busy_rdy !== 1'b0) begin errors++; $display("FAIL zero_busy_ready got %b exp 0", busy_rdy); end
        checks++; if (lat != 10) begin errors++; $display("FAIL zero_latency got %0d exp 10", lat); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b exp 0", done_after); end
        checks++; if (segs !== {S_OFF, S_OFF, S_OFF, S_D0}) begin
            errors++; $display("FAIL zero_digits got %h exp %h", segs, {S_OFF, S_OFF, S_OFF, S_D0});
        end
    endtask

    task automatic test_positive;
        int          lat;
        logic        busy_rdy;
        logic        done_after;
        logic [27:0] segs;
        do_sample(8'd127, lat, busy_rdy, done_after, segs);
        checks++; if (lat != 10) begin errors++; $display("FAIL p127_latency got %0d exp 10", lat); end
        checks++; if (segs !== {S_OFF, S_D1, S_D2, S_D7}) begin
            errors++; $display("FAIL p127_digits got %h exp %h", segs, {S_OFF, S_D1, S_D2, S_D7});
        end
    endtask

    task automatic test_negative;
        int          lat;
        logic        busy_rdy;
        logic        done_after;
        logic [27:0] segs;
        do_sample(8'h80, lat, busy_rdy, done_after, segs);
        checks++; if (segs !== {S_MIN, S_D1, S_D2, S_D8}) begin
            errors++; $display("FAIL n128_digits got %h exp %h", segs, {S_MIN, S_D1, S_D2, S_D8});
        end
        do_sample(8'hFF, lat, busy_rdy, done_after, segs);
        checks++; if (segs !== {S_MIN, S_OFF, S_OFF, S_D1}) begin
            errors++; $display("FAIL n1_digits got %h exp %h", segs, {S_MIN, S_OFF, S_OFF, S_D1});
        end
        checks++; if (lat != 10) begin errors++; $display("FAIL n1_latency got %0d exp 10", lat); end
    endtask

    task automatic test_back_to_back;
        int          hs_t [2];
        int          done_t [2];
        int          nhs;
        int          ndone;
        logic        hs_now;
        logic [6:0]  exp_seg;
        logic [27:0] segs;
        nhs = 0; ndone = 0;
        @(negedge clk);
        i_data  = 8'hF6;
        i_valid = 1'b1;
        for (int c = 0; c < 60 && ndone < 2; c++) begin
            if (o_done === 1'b1) begin
                done_t[ndone] = cyc;
                ndone++;
            end
            // -10 must be on display from the first o_done until the next LATCH load
            if (ndone == 1 && (cyc - done_t[0]) < 10) begin
                case (o_an)
                    4'b1110: exp_seg = S_D0;
                    4'b1101: exp_seg = S_D1;
                    4'b1011: exp_seg = S_OFF;
                    4'b0111: exp_seg = S_MIN;
                    default: exp_seg = 'x;
                endcase
                checks++;
                if (o_seg !== exp_seg) begin
                    errors++; $display("FAIL b2b_hold an=%b got %h exp %h", o_an, o_seg, exp_seg);
                end
            end
            hs_now = o_ready && i_valid;
            if (hs_now && nhs < 2) begin
                hs_t[nhs] = cyc + 1;
                nhs++;
            end
            @(posedge clk); #1;
            if (hs_now) begin
                if (nhs == 1) i_data = 8'd45;
                else          i_valid = 1'b0;
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        checks++; if (nhs != 2 || ndone != 2) begin
            errors++; $display("FAIL b2b_counts got hs=%0d done=%0d exp 2/2", nhs, ndone);
        end else begin
            $display("b2b: handshakes at %0d,%0d done at %0d,%0d", hs_t[0], hs_t[1], done_t[0], done_t[1]);
            checks++; if (hs_t[1] - hs_t[0] != 11) begin
                errors++; $display("FAIL b2b_spacing got %0d exp 11", hs_t[1] - hs_t[0]);
            end
            checks++; if (done_t[1] - hs_t[1] != 10) begin
                errors++; $display("FAIL b2b_latency got %0d exp 10", done_t[1] - hs_t[1]);
            end
        end
        read_digits(segs);
        checks++; if (segs !== {S_OFF, S_OFF, S_D4, S_D5}) begin
            errors++; $display("FAIL b2b_digits got %h exp %h", segs, {S_OFF, S_OFF, S_D4, S_D5});
        end
    endtask

    task automatic test_scan;
        logic [3:0] pats [4];
        logic [3:0] prev;
        logic       found;
        pats  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        found = 1'b0;
        @(negedge clk);
        prev = o_an;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (prev === 4'b1110 && o_an === 4'b1101) found = 1'b1;
            else prev = o_an;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL scan_sync got %b exp 1110->1101", o_an);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (o_an !== pats[i/4]) begin
                    errors++; $display("FAIL scan_step %0d got %b exp %b", i, o_an, pats[i/4]);
                end
                @(negedge clk);
            end
            $display("scan: 16 cycles compared");
        end
    endtask

    task automatic test_reset_mid;
        int          lat;
        logic        busy_rdy;
        logic        done_after;
        logic [27:0] segs;
        int          hs;
        int          c;
        int          dones;
        do_sample(8'd42, lat, busy_rdy, done_after, segs);
        checks++; if (segs !== {S_OFF, S_OFF, S_D4, S_D2}) begin
            errors++; $display("FAIL p42_digits got %h exp %h", segs, {S_OFF, S_OFF, S_D4, S_D2});
        end
        @(negedge clk);
        i_data  = 8'd99;
        i_valid = 1'b1;
        c = 0;
        while (!o_ready && c < 40) begin @(negedge clk); c++; end
        hs = cyc + 1;
        @(posedge clk); #1 i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b1;
        @(posedge clk); #1 i_rst = 1'b0;
        $display("reset_mid: handshake %0d, reset sampled at %0d", hs, cyc);
        @(negedge clk);
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b exp 1", o_ready); end
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (o_done === 1'b1) dones++;
            @(negedge clk);
        end
        checks++; if (dones != 0) begin errors++; $display("FAIL mid_done got %0d pulses exp 0", dones); end
        read_digits(segs);
        checks++; if (segs !== {S_OFF, S_OFF, S_OFF, S_D0}) begin
            errors++; $display("FAIL mid_digits got %h exp %h", segs, {S_OFF, S_OFF, S_OFF, S_D0});
        end
    endtask

    initial begin
        test_reset();
        test_positive();
        test_negative();
        test_back_to_back();
        test_scan();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
